// File: rtl/fetch_pkg.sv
// Shared types and encodings for the fetch sequencer: PC-source select,
// injected micro-instruction opcodes and sequencer states.
package fetch_pkg;

  // Address the fetch stage loads while pc_sel = RST.
  localparam logic [31:0] RESET_PC = 32'h0000_0020;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    BRANCH = 3'd1,
    POP    = 3'd2,
    VECTOR = 3'd3,
    HOLD   = 3'd4,
    RST    = 3'd5
  } pc_sel_t;

  localparam logic [4:0] OP_PUSHF  = 5'b11110;
  localparam logic [4:0] OP_PUSHPC = 5'b11111;
  localparam logic [4:0] OP_JMPR   = 5'b11011;
  localparam logic [4:0] OP_POPF   = 5'b11101;
  localparam logic [4:0] OP_NOP    = 5'b00000;

  typedef enum logic [3:0] {
    S_RESET,
    S_IDLE,
    S_INT_DRAIN,
    S_INT_PUSHF,
    S_INT_PUSHPC,
    S_INT_VEC,
    S_CALL_PUSHPC,
    S_CALL_JMP,
    S_RTI_POPF,
    S_RET_WAIT
  } seq_state_t;

  // Injected word layout: {op, rs, rd, shmnt}.
  function automatic logic [15:0] mk_inst(input logic [4:0] op, input logic [2:0] rd);
    return {op, 3'b000, rd, 5'b00000};
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-side control FSM: interrupt entry, CALL expansion and RET/RTI
// sequencing, driving PC-source select, injected instruction and flush.
//
// state         | meaning
// S_RESET       | reset held / first cycle after release, PC forced to reset vector
// S_IDLE        | sequential fetch, arbitrates branch/interrupt/decode events
// S_INT_DRAIN   | inject NOPs while older instructions drain
// S_INT_PUSHF   | inject PUSHF
// S_INT_PUSHPC  | inject PUSHPC
// S_INT_VEC     | redirect PC to interrupt vector, acknowledge
// S_CALL_PUSHPC | inject PUSHPC for a CALL
// S_CALL_JMP    | inject JMPR to the CALL target register
// S_RTI_POPF    | inject POPF for an RTI
// S_RET_WAIT    | inject NOPs until the popped PC arrives
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        int_req,
  input  logic        dec_call,
  input  logic        dec_ret,
  input  logic        dec_rti,
  input  logic [2:0]  dec_rdst,
  input  logic        branch_taken,
  input  logic        pop_valid,
  output logic [2:0]  pc_sel,
  output logic        inject_valid,
  output logic [15:0] inject_inst,
  output logic        flush_fetch,
  output logic        int_ack,
  output logic        busy
);

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  seq_state_t state, state_next;
  logic [2:0] drain_cnt, cnt_next;
  logic [2:0] rdst_q, rdst_next;
  logic       int_pending, clr_pending;
  logic       busy_q;
  pc_sel_t    sel;
  logic       inj_v, flush, ack;
  logic [15:0] inj;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RESET;
      drain_cnt   <= 3'd0;
      rdst_q      <= 3'd0;
      int_pending <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state     <= state_next;
      drain_cnt <= cnt_next;
      rdst_q    <= rdst_next;
      busy_q    <= (state_next != S_IDLE);
      if (clr_pending)
        int_pending <= 1'b0;
      else if (int_req)
        int_pending <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = drain_cnt;
    rdst_next   = rdst_q;
    clr_pending = 1'b0;
    sel         = SEQ;
    inj_v       = 1'b0;
    inj         = 16'h0000;
    flush       = 1'b0;
    ack         = 1'b0;

    case (state)
      S_RESET: begin
        sel        = RST;
        flush      = 1'b1;
        state_next = S_IDLE;
      end
      S_IDLE: begin
        // A same-cycle int_req counts as pending so entry latency is DRAIN_CYCLES+3.
        if (branch_taken) begin
          sel   = BRANCH;
          flush = 1'b1;
        end else if (int_pending || int_req) begin
          state_next = S_INT_DRAIN;
          cnt_next   = DRAIN_INIT;
        end else if (dec_rti) begin
          state_next = S_RTI_POPF;
        end else if (dec_ret) begin
          state_next = S_RET_WAIT;
        end else if (dec_call) begin
          rdst_next  = dec_rdst;
          state_next = S_CALL_PUSHPC;
        end
      end
      S_INT_DRAIN: begin
        inj_v = 1'b1;
        inj   = mk_inst(OP_NOP, 3'd0);
        sel   = branch_taken ? BRANCH : HOLD;
        if (drain_cnt == 3'd0)
          state_next = S_INT_PUSHF;
        else
          cnt_next = drain_cnt - 3'd1;
      end
      S_INT_PUSHF: begin
        inj_v      = 1'b1;
        inj        = mk_inst(OP_PUSHF, 3'd0);
        sel        = HOLD;
        state_next = S_INT_PUSHPC;
      end
      S_INT_PUSHPC: begin
        inj_v      = 1'b1;
        inj        = mk_inst(OP_PUSHPC, 3'd0);
        sel        = HOLD;
        state_next = S_INT_VEC;
      end
      S_INT_VEC: begin
        sel         = VECTOR;
        ack         = 1'b1;
        flush       = 1'b1;
        clr_pending = 1'b1;
        state_next  = S_IDLE;
      end
      S_CALL_PUSHPC, S_CALL_JMP, S_RTI_POPF, S_RET_WAIT: begin
        // An older branch resolving in EX wins over the whole sequence.
        if (branch_taken) begin
          sel        = BRANCH;
          flush      = 1'b1;
          rdst_next  = 3'd0;
          state_next = S_IDLE;
        end else begin
          sel   = HOLD;
          inj_v = 1'b1;
          case (state)
            S_CALL_PUSHPC: begin
              inj        = mk_inst(OP_PUSHPC, rdst_q);
              state_next = S_CALL_JMP;
            end
            S_CALL_JMP: begin
              inj        = mk_inst(OP_JMPR, rdst_q);
              state_next = S_IDLE;
            end
            S_RTI_POPF: begin
              inj        = mk_inst(OP_POPF, 3'd0);
              state_next = S_RET_WAIT;
            end
            default: begin
              inj = mk_inst(OP_NOP, 3'd0);
              if (pop_valid) begin
                inj_v      = 1'b0;
                sel        = POP;
                flush      = 1'b1;
                state_next = S_IDLE;
              end
            end
          endcase
        end
      end
      default: state_next = S_RESET;
    endcase

    // Stall: freeze everything but the interrupt latch; reset state keeps its outputs.
    if (!enable) begin
      state_next  = state;
      cnt_next    = drain_cnt;
      rdst_next   = rdst_q;
      clr_pending = 1'b0;
      ack         = 1'b0;
      if (state != S_RESET) begin
        sel   = HOLD;
        flush = 1'b0;
      end
    end
  end

  assign pc_sel       = sel;
  assign inject_valid = inj_v;
  assign inject_inst  = inj;
  assign flush_fetch  = flush;
  assign int_ack      = ack;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, interrupt entry, CALL, RTI,
// branch abort/redirect, stall and mid-sequence reset.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        int_req;
  logic        dec_call;
  logic        dec_ret;
  logic        dec_rti;
  logic [2:0]  dec_rdst;
  logic        branch_taken;
  logic        pop_valid;
  logic [2:0]  pc_sel;
  logic        inject_valid;
  logic [15:0] inject_inst;
  logic        flush_fetch;
  logic        int_ack;
  logic        busy;

  int vectors;
  int miscompares;

  fetch_sequencer #(.DRAIN_CYCLES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .int_req      (int_req),
    .dec_call     (dec_call),
    .dec_ret      (dec_ret),
    .dec_rti      (dec_rti),
    .dec_rdst     (dec_rdst),
    .branch_taken (branch_taken),
    .pop_valid    (pop_valid),
    .pc_sel       (pc_sel),
    .inject_valid (inject_valid),
    .inject_inst  (inject_inst),
    .flush_fetch  (flush_fetch),
    .int_ack      (int_ack),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string tag, input pc_sel_t e);
    #1;
    vectors++;
    assert (pc_sel === e) else begin
      miscompares++;
      $error("FAIL %s pc_sel observed=%0d expected=%0d", tag, pc_sel, e);
    end
  endtask

  task automatic chk_bit(input string tag, input logic o, input logic e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk_inst(input string tag, input logic [15:0] e);
    vectors++;
    assert (inject_inst === e) else begin
      miscompares++;
      $error("FAIL %s inject_inst observed=%h expected=%h", tag, inject_inst, e);
    end
  endtask

  // Instruction word is only compared while an injection is expected.
  task automatic expect_out(input string tag, input pc_sel_t sel, input logic iv,
                            input logic [15:0] inst, input logic fl, input logic ack);
    chk_sel(tag, sel);
    chk_bit({tag, " inject_valid"}, inject_valid, iv);
    if (iv) chk_inst(tag, inst);
    chk_bit({tag, " flush_fetch"}, flush_fetch, fl);
    chk_bit({tag, " int_ack"}, int_ack, ack);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    enable       = 1'b1;
    int_req      = 1'b0;
    dec_call     = 1'b0;
    dec_ret      = 1'b0;
    dec_rti      = 1'b0;
    dec_rdst     = 3'd0;
    branch_taken = 1'b0;
    pop_valid    = 1'b0;

    // 1. Reset
    tick(); tick(); tick();
    expect_out("rst", RST, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_inst("rst inst", 16'h0000);
    chk_bit("rst busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    expect_out("idle", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_bit("idle busy", busy, 1'b0);

    // Branch in IDLE
    branch_taken = 1'b1;
    expect_out("idle br", BRANCH, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    branch_taken = 1'b0;
    chk_bit("idle br busy", busy, 1'b0);

    // 2. Interrupt entry
    int_req = 1'b1;
    expect_out("int req", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    int_req = 1'b0;
    expect_out("int drain0", HOLD, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_bit("int busy", busy, 1'b1);
    tick(); expect_out("int drain1", HOLD, 1'b1, 16'h0000, 1'b0, 1'b0);
    tick(); expect_out("int drain2", HOLD, 1'b1, 16'h0000, 1'b0, 1'b0);
    tick(); expect_out("int pushf", HOLD, 1'b1, 16'hF000, 1'b0, 1'b0);
    tick(); expect_out("int pushpc", HOLD, 1'b1, 16'hF800, 1'b0, 1'b0);
    tick(); expect_out("int vec", VECTOR, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick(); expect_out("int done", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_bit("int done busy", busy, 1'b0);
    tick(); expect_out("int cleared", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);

    // 3. CALL r5
    dec_call = 1'b1; dec_rdst = 3'd5;
    tick();
    dec_call = 1'b0; dec_rdst = 3'd0;
    expect_out("call pushpc", HOLD, 1'b1, 16'hF8A0, 1'b0, 1'b0);
    tick(); expect_out("call jmp", HOLD, 1'b1, 16'hD8A0, 1'b0, 1'b0);
    tick(); expect_out("call done", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_bit("call done busy", busy, 1'b0);

    // 4. RTI, pop_valid four cycles into RET_WAIT
    dec_rti = 1'b1;
    dec_ret = 1'b1;
    tick();
    dec_rti = 1'b0;
    dec_ret = 1'b0;
    expect_out("rti popf", HOLD, 1'b1, 16'hE800, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("rti wait", HOLD, 1'b1, 16'h0000, 1'b0, 1'b0);
    end
    tick();
    pop_valid = 1'b1;
    chk_sel("rti pop", POP);
    chk_bit("rti pop flush", flush_fetch, 1'b1);
    tick();
    pop_valid = 1'b0;
    expect_out("rti done", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);

    // 5a. Branch aborts CALL_JMP
    dec_call = 1'b1; dec_rdst = 3'd2;
    tick();
    dec_call = 1'b0;
    expect_out("abort pushpc", HOLD, 1'b1, 16'hF840, 1'b0, 1'b0);
    tick();
    branch_taken = 1'b1;
    chk_sel("abort br", BRANCH);
    chk_bit("abort flush", flush_fetch, 1'b1);
    tick();
    branch_taken = 1'b0;
    expect_out("abort idle", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_bit("abort busy", busy, 1'b0);

    // 5b. Branch during drain redirects but the entry completes
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    expect_out("dbr drain0", HOLD, 1'b1, 16'h0000, 1'b0, 1'b0);
    tick();
    branch_taken = 1'b1;
    chk_sel("dbr drain1 br", BRANCH);
    chk_bit("dbr drain1 iv", inject_valid, 1'b1);
    tick();
    branch_taken = 1'b0;
    expect_out("dbr drain2", HOLD, 1'b1, 16'h0000, 1'b0, 1'b0);
    tick(); expect_out("dbr pushf", HOLD, 1'b1, 16'hF000, 1'b0, 1'b0);
    tick(); expect_out("dbr pushpc", HOLD, 1'b1, 16'hF800, 1'b0, 1'b0);
    tick(); expect_out("dbr vec", VECTOR, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick(); expect_out("dbr done", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);

    // 6a. Stall in INT_PUSHF
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick(); tick(); tick();
    expect_out("stall pushf", HOLD, 1'b1, 16'hF000, 1'b0, 1'b0);
    enable = 1'b0;
    expect_out("stall0", HOLD, 1'b1, 16'hF000, 1'b0, 1'b0);
    tick(); expect_out("stall1", HOLD, 1'b1, 16'hF000, 1'b0, 1'b0);
    tick();
    enable = 1'b1;
    expect_out("stall resume", HOLD, 1'b1, 16'hF000, 1'b0, 1'b0);
    tick(); expect_out("stall pushpc", HOLD, 1'b1, 16'hF800, 1'b0, 1'b0);

    // 6b. Reset in INT_PUSHPC takes effect immediately and drops the request
    reset = 1'b0;
    expect_out("midrst", RST, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_inst("midrst inst", 16'h0000);
    chk_bit("midrst busy", busy, 1'b1);
    tick(); tick();
    reset = 1'b1;
    tick(); expect_out("midrst idle", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(); expect_out("midrst nopend", SEQ, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk_bit("midrst nopend busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
